// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch unit redirect, imem and decode-side signal bundle
interface fetch_unit_if;
    logic        redirect_in;
    logic [31:0] redirect_pc_in;
    logic        imem_req_valid_out;
    logic        imem_req_ready_in;
    logic [31:0] imem_addr_out;
    logic        imem_resp_valid_in;
    logic [31:0] imem_resp_data_in;
    logic        instr_valid_out;
    logic        instr_ready_in;
    logic [31:0] instr_out;
    logic [31:0] pc_out;

    // Fetch unit side
    modport master (
        input  redirect_in, redirect_pc_in,
        input  imem_req_ready_in, imem_resp_valid_in, imem_resp_data_in,
        input  instr_ready_in,
        output imem_req_valid_out, imem_addr_out,
        output instr_valid_out, instr_out, pc_out
    );

    // Environment side: branch resolution, instruction memory and decode
    modport slave (
        output redirect_in, redirect_pc_in,
        output imem_req_ready_in, imem_resp_valid_in, imem_resp_data_in,
        output instr_ready_in,
        input  imem_req_valid_out, imem_addr_out,
        input  instr_valid_out, instr_out, pc_out
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with single outstanding request and fetch queue
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);

    localparam int CW = $clog2(QDEPTH + 1);

    // REQ: free to issue, WAIT: response kept, DROP: response discarded
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q;
    logic [31:0]   inflight_pc_q;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] wr_idx;
    logic [31:0]   q_pc      [QDEPTH];
    logic [31:0]   q_ins     [QDEPTH];
    logic [31:0]   q_pc_d    [QDEPTH];
    logic [31:0]   q_ins_d   [QDEPTH];

    logic room;
    logic req_fire;
    logic resp_in;
    logic push;
    logic pop;

    // A request is only issued when its response is guaranteed a queue slot,
    // so responses never need back-pressure.
    assign room                   = (count_q < CW'(QDEPTH));
    assign bus.imem_req_valid_out = !reset && (state_q == S_REQ) && room && !bus.redirect_in;
    assign bus.imem_addr_out      = fetch_pc_q;
    assign req_fire               = bus.imem_req_valid_out && bus.imem_req_ready_in;
    assign resp_in                = bus.imem_resp_valid_in;

    // Queue head is the flop at index 0; entries shift toward it on pop
    assign bus.instr_valid_out = (count_q != '0);
    assign bus.instr_out       = q_ins[0];
    assign bus.pc_out          = q_pc[0];

    // A redirect overrides both queue operations: the flush wins
    assign push   = (state_q == S_WAIT) && resp_in && !bus.redirect_in;
    assign pop    = bus.instr_valid_out && bus.instr_ready_in && !bus.redirect_in;
    assign wr_idx = count_q - CW'(pop);

    // FSM next-state: redirect while outstanding turns the pending response into a drop
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ: begin
                if (req_fire) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (resp_in) begin
                    state_d = S_REQ;
                end else if (bus.redirect_in) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (resp_in) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Fetch PC advances on acceptance; a redirect realigns it to a word boundary
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
        end else if (bus.redirect_in) begin
            fetch_pc_q    <= bus.redirect_pc_in & 32'hFFFF_FFFC;
        end else if (req_fire) begin
            fetch_pc_q    <= fetch_pc_q + 32'd4;
            inflight_pc_q <= fetch_pc_q;
        end
    end

    // Queue next-state: shift on pop, then write the response behind the last live entry
    always_comb begin
        count_d = count_q;
        q_pc_d  = q_pc;
        q_ins_d = q_ins;
        if (bus.redirect_in) begin
            count_d = '0;
        end else begin
            if (pop) begin
                for (int i = 0; i < QDEPTH - 1; i++) begin
                    q_pc_d[i]  = q_pc[i + 1];
                    q_ins_d[i] = q_ins[i + 1];
                end
            end
            if (push) begin
                for (int i = 0; i < QDEPTH; i++) begin
                    if (CW'(i) == wr_idx) begin
                        q_pc_d[i]  = inflight_pc_q;
                        q_ins_d[i] = bus.imem_resp_data_in;
                    end
                end
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Queue storage and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_pc[i]  <= '0;
                q_ins[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            q_pc    <= q_pc_d;
            q_ins   <= q_ins_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed vector bench for fetch_unit
module tb_fetch_unit;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit          rst;
        bit          redir;
        logic [31:0] rpc;
        bit          rreq;
        bit          rv;
        logic [31:0] rd;
        bit          iready;
        bit          e_rv;
        logic [31:0] e_addr;
        bit          e_iv;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] BAD = 32'hBAD0_0000;

    function automatic logic [31:0] dat(input logic [31:0] a);
        return 32'hD000_0000 | a;
    endfunction

    function automatic vec_t mk(input bit rst, input bit redir, input logic [31:0] rpc,
                                input bit rreq, input bit rv, input logic [31:0] rd,
                                input bit iready, input bit e_rv, input logic [31:0] e_addr,
                                input bit e_iv, input logic [31:0] e_pc, input logic [31:0] e_ins);
        vec_t v;
        v.rst = rst; v.redir = redir; v.rpc = rpc; v.rreq = rreq; v.rv = rv; v.rd = rd;
        v.iready = iready; v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv;
        v.e_pc = e_pc; v.e_ins = e_ins;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add_reset();
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic drive_idle();
        bus.redirect_in        = 1'b0;
        bus.redirect_pc_in     = '0;
        bus.imem_req_ready_in  = 1'b0;
        bus.imem_resp_valid_in = 1'b0;
        bus.imem_resp_data_in  = '0;
        bus.instr_ready_in     = 1'b0;
    endtask

    int          t_req, t_val, t_val2;
    logic [31:0] a_req, p_val, i_val, p_val2, pend_addr;
    bit          pend;

    initial begin
        drive_idle();

        // 1: steady stream after reset
        add_reset();
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 32'h0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, dat(32'h0), 1, 0, 32'h4, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 32'h4, 1, 32'h0, dat(32'h0)));
        vecs.push_back(mk(0, 0, 0, 1, 1, dat(32'h4), 1, 0, 32'h8, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 32'h8, 1, 32'h4, dat(32'h4)));
        vecs.push_back(mk(0, 0, 0, 1, 1, dat(32'h8), 1, 0, 32'hC, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'hC, 1, 32'h8, dat(32'h8)));
        // 2: decode stalled, queue fills, then drains in order
        add_reset();
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 32'h0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, dat(32'h0), 0, 0, 32'h4, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 32'h4, 1, 32'h0, dat(32'h0)));
        vecs.push_back(mk(0, 0, 0, 1, 1, dat(32'h4), 0, 0, 32'h8, 1, 32'h0, dat(32'h0)));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 32'h8, 1, 32'h0, dat(32'h0)));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 32'h8, 1, 32'h0, dat(32'h0)));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 32'h8, 1, 32'h4, dat(32'h4)));
        vecs.push_back(mk(0, 0, 0, 1, 1, dat(32'h8), 1, 0, 32'hC, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'hC, 1, 32'h8, dat(32'h8)));
        // 3: redirect during WAIT, late response dropped
        add_reset();
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 32'h0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h100, 1, 0, 0, 1, 0, 32'h4, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 0, 32'h100, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, BAD, 1, 0, 32'h100, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 32'h100, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, dat(32'h100), 1, 0, 32'h104, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h104, 1, 32'h100, dat(32'h100)));
        // 4: redirect with coincident response, back-to-back redirects, PC wrap
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 32'h104, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h203, 1, 1, dat(32'h104), 1, 0, 32'h108, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h200, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h300, 1, 0, 0, 1, 0, 32'h200, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h404, 1, 0, 0, 1, 0, 32'h300, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h404, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'hFFFF_FFFE, 1, 0, 0, 1, 0, 32'h404, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 32'hFFFF_FFFC, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 32'h1234_5678, 1, 0, 32'h0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h0, 1, 32'hFFFF_FFFC, 32'h1234_5678));
        // 5: memory not ready for 3 cycles, then redirect flushes a full-ish queue
        add_reset();
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 32'h0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, dat(32'h0), 0, 0, 32'h4, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 32'h4, 1, 32'h0, dat(32'h0)));
        vecs.push_back(mk(0, 1, 32'h40, 1, 0, 0, 1, 0, 32'h8, 1, 32'h0, dat(32'h0)));
        vecs.push_back(mk(0, 0, 0, 1, 1, BAD, 1, 0, 32'h40, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h40, 0, 0, 0));
        // 6: reset during WAIT with one queued entry, late response ignored
        add_reset();
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 32'h0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, dat(32'h0), 0, 0, 32'h4, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 32'h4, 1, 32'h0, dat(32'h0)));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h8, 1, 32'h0, dat(32'h0)));
        vecs.push_back(mk(1, 0, 0, 0, 1, BAD, 0, 0, 32'h0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, BAD, 0, 1, 32'h0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 32'h0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, dat(32'h0), 0, 0, 32'h4, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h4, 1, 32'h0, dat(32'h0)));

        foreach (vecs[n]) begin
            @(posedge clk);
            #1;
            reset                  = vecs[n].rst;
            bus.redirect_in        = vecs[n].redir;
            bus.redirect_pc_in     = vecs[n].rpc;
            bus.imem_req_ready_in  = vecs[n].rreq;
            bus.imem_resp_valid_in = vecs[n].rv;
            bus.imem_resp_data_in  = vecs[n].rd;
            bus.instr_ready_in     = vecs[n].iready;
            @(negedge clk);
            chk($sformatf("v%0d req_valid", n), 32'(bus.imem_req_valid_out), 32'(vecs[n].e_rv));
            chk($sformatf("v%0d addr", n), bus.imem_addr_out, vecs[n].e_addr);
            chk($sformatf("v%0d instr_valid", n), 32'(bus.instr_valid_out), 32'(vecs[n].e_iv));
            if (vecs[n].e_iv || vecs[n].rst) begin
                chk($sformatf("v%0d pc", n), bus.pc_out, vecs[n].e_pc);
                chk($sformatf("v%0d instr", n), bus.instr_out, vecs[n].e_ins);
            end
        end

        // Reset asserted between clock edges clears the queue at once
        drive_idle();
        chk("async_pre_valid", 32'(bus.instr_valid_out), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_valid", 32'(bus.instr_valid_out), 32'd0);
        chk("async_req_valid", 32'(bus.imem_req_valid_out), 32'd0);
        chk("async_pc", bus.pc_out, 32'h0);
        chk("async_addr", bus.imem_addr_out, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Redirect latency and steady cadence with a 1-cycle memory
        @(posedge clk);
        #1;
        bus.redirect_in       = 1'b1;
        bus.redirect_pc_in    = 32'h80;
        bus.imem_req_ready_in = 1'b1;
        bus.instr_ready_in    = 1'b1;
        @(negedge clk);
        chk("redir_noreq", 32'(bus.imem_req_valid_out), 32'd0);
        pend = 1'b0; pend_addr = '0;
        t_req = -1; t_val = -1; t_val2 = -1;
        a_req = '0; p_val = '0; i_val = '0; p_val2 = '0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            bus.redirect_in        = 1'b0;
            bus.imem_resp_valid_in = pend;
            bus.imem_resp_data_in  = dat(pend_addr);
            @(negedge clk);
            pend = bus.imem_req_valid_out && bus.imem_req_ready_in;
            if (pend) pend_addr = bus.imem_addr_out;
            if (pend && t_req < 0) begin
                t_req = k;
                a_req = bus.imem_addr_out;
            end
            if (bus.instr_valid_out) begin
                if (t_val < 0) begin
                    t_val = k; p_val = bus.pc_out; i_val = bus.instr_out;
                end else if (t_val2 < 0) begin
                    t_val2 = k; p_val2 = bus.pc_out;
                end
            end
        end
        chk("lat_req_cycle", 32'(t_req), 32'd1);
        chk("lat_req_addr", a_req, 32'h80);
        chk("lat_valid_cycle", 32'(t_val), 32'd3);
        chk("lat_pc", p_val, 32'h80);
        chk("lat_instr", i_val, dat(32'h80));
        chk("lat_second_cycle", 32'(t_val2), 32'd5);
        chk("lat_second_pc", p_val2, 32'h84);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage, directly upstream of the branch/jump resolution unit.
- Holds the fetch PC and issues word requests to instruction memory, one outstanding request at a time.
- Buffers returned {pc, instruction} pairs in a small queue for decode.
- Consumes the resolution unit's redirect (mispredict flag + target PC): flushes its queue and discards any in-flight response.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- QDEPTH, 2, fetch-queue entries (>=1).

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- redirect_in  input  1  redirect request from branch resolution (mispredict/jump taken)
- redirect_pc_in  input  32  new fetch target
- imem_req_valid_out  output  1  fetch request valid
- imem_req_ready_in  input  1  memory accepts request
- imem_addr_out  output  32  fetch address, word aligned
- imem_resp_valid_in  input  1  response data valid; never earlier than 1 cycle after acceptance
- imem_resp_data_in  input  32  fetched instruction
- instr_valid_out  output  1  queue head valid
- instr_ready_in  input  1  decode consumes head
- instr_out  output  32  head instruction
- pc_out  output  32  head PC

Behaviour:
- Reset (async, immediate):
  - fetch_pc = RESET_PC; state = REQ; queue empty; inflight_pc = 0.
  - Outputs: instr_valid_out=0, instr_out=0, pc_out=0, imem_addr_out=RESET_PC, imem_req_valid_out=0 while reset is asserted.
- FSM states:
  - REQ: may issue a request.
  - WAIT: one request outstanding, response will be kept.
  - DROP: one request outstanding, response will be discarded.
- Request issue:
  - imem_req_valid_out = (state==REQ) && (count < QDEPTH) && !redirect_in.
  - imem_addr_out = fetch_pc.
  - Handshake (valid && ready): inflight_pc <= fetch_pc; fetch_pc <= fetch_pc + 4 (mod 2^32, wraps 0xFFFF_FFFC -> 0); state <= WAIT.
  - Free-slot rule: a request is issued only when the queue can take its response, so a response is never dropped for lack of space. Responses can only arrive while a request is outstanding, i.e. while state is WAIT or DROP; in REQ the count check therefore covers all incoming data.
- Response:
  - In WAIT with imem_resp_valid_in: push {inflight_pc, imem_resp_data_in}; state <= REQ.
  - In DROP with imem_resp_valid_in: data discarded; state <= REQ.
  - imem_resp_valid_in in REQ is ignored.
- Queue:
  - FIFO; instr_valid_out = (count != 0); instr_out/pc_out show the head entry, registered.
  - Pop when instr_valid_out && instr_ready_in.
  - Simultaneous push and pop, including when full: count unchanged, ordering preserved.
  - Empty queue shows the last values or 0; never valid.
- Redirect (highest priority, checked every cycle):
  - Queue flushed: count <= 0, so instr_valid_out=0 from the next cycle.
  - fetch_pc <= {redirect_pc_in[31:2], 2'b00}.
  - No request is issued in the redirect cycle.
  - Next state:
    - state WAIT and no response this cycle -> DROP.
    - state WAIT with response this cycle -> response discarded (not pushed), REQ.
    - state DROP -> stays DROP unless a response arrives this cycle, then REQ.
    - state REQ -> REQ.
  - A pop in the same cycle has no effect beyond the flush.
  - Back-to-back redirects: the last one wins.
- Latency:
  - Redirect at cycle N, no request outstanding, imem ready, 1-cycle memory: request at N+1, response at N+2, instr_valid_out at N+3.
  - Steady state with a 1-cycle memory: one instruction every 2 cycles (single outstanding request).

Test Plan:
1. Reset release, RESET_PC=0, imem always ready, 1-cycle response, decode always ready -> requests at 0x0, 0x4, 0x8; pc_out/instr_out sequence 0x0/D0, 0x4/D1, 0x8/D2, each valid 1 cycle after its response.
2. instr_ready_in=0 held, QDEPTH=2 -> exactly two entries queued (0x0, 0x4), imem_req_valid_out stays 0; raise ready -> pops in order, fetching resumes at 0x8.
3. Redirect to 0x100 while in WAIT, response arrives 2 cycles later -> that response discarded, next accepted address 0x100, first delivered pc_out=0x100, no stale instruction valid.
4. Redirect to 0x203 coinciding with a response -> response not pushed, queue empty next cycle, next imem_addr_out=0x200.
5. imem_req_ready_in low 3 cycles -> imem_req_valid_out and imem_addr_out stable, fetch_pc not incremented until acceptance.
6. Reset asserted mid-WAIT with queue holding 1 entry -> instr_valid_out=0 immediately, after release first request address = RESET_PC, late response ignored.
